io_uart_tx_responder: RTL and testbench

- Memory-mapped UART transmitter peripheral on the core's IO bus.
- Acts as the responder for the core's IO_mem_addr / IO_mem_wdata / IO_mem_wr / IO_mem_rdata initiator interface.
- Stores written bytes in a TX FIFO and serialises them 8N1 on uart_txd.
- Returns status and configuration on IO_mem_rdata, combinationally, in the same cycle as the address.

---
 rtl/io_uart_tx_responder_pkg.sv | 24 ++
 rtl/io_uart_tx_responder_if.sv | 24 ++
 rtl/io_uart_tx_responder_fifo.sv | 56 +++++
 rtl/io_uart_tx_responder.sv | 185 ++++++++++++++++++
 tb/tb_io_uart_tx_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_uart_tx_responder_pkg.sv
// Shared constants for the IO-bus UART transmitter:
// register offsets, STATUS bit positions, FSM states.
package io_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/io_uart_tx_responder_if.sv
// Core IO-bus initiator/responder bundle.
// master: core drives addr/wdata/wr; slave: returns rdata.
interface io_uart_tx_responder_if;

  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (
    output IO_mem_addr,
    output IO_mem_wdata,
    output IO_mem_wr,
    input  IO_mem_rdata
  );

  modport slave (
    input  IO_mem_addr,
    input  IO_mem_wdata,
    input  IO_mem_wr,
    output IO_mem_rdata
  );

endinterface

// File: rtl/io_uart_tx_responder_fifo.sv
// Synchronous FIFO with show-ahead head (dout).
// Ports: push/pop/din in; dout/full/empty/count out.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap
  // modulo DEPTH on their own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter on the IO bus.
// Ports: clk, resetn, bus (slave), uart_txd, tx_idle.
module io_uart_tx_responder
  import io_uart_pkg::*;
#(
  parameter  int FIFO_DEPTH  = 16,
  parameter  int DEFAULT_DIV = 217,
  parameter  int DIV_BITS    = 16,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic resetn,
  io_uart_tx_responder_if.slave bus,
  output logic uart_txd,
  output logic tx_idle
);

  logic                w_sel;
  logic [1:0]          w_idx;
  logic                w_wr;
  logic                w_wr_data;
  logic                w_wr_stat;
  logic                w_wr_div;
  logic [DIV_BITS-1:0] w_div_in;
  logic                w_unused;

  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [7:0]          w_dout;
  logic                w_push;
  logic                w_pop;
  logic                w_bit_end;

  logic [DIV_BITS-1:0] r_div;
  logic                r_ovf;
  uart_state_e         r_state;
  logic [DIV_BITS-1:0] r_baud;
  logic [DIV_BITS-1:0] r_div_q;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;

  assign w_sel     = bus.IO_mem_addr[22];
  assign w_idx     = bus.IO_mem_addr[3:2];
  assign w_wr      = bus.IO_mem_wr & w_sel;
  assign w_wr_data = w_wr & (w_idx == REG_DATA);
  assign w_wr_stat = w_wr & (w_idx == REG_STATUS);
  assign w_wr_div  = w_wr & (w_idx == REG_DIV);
  assign w_div_in  = bus.IO_mem_wdata[DIV_BITS-1:0];
  assign w_push    = w_wr_data & ~w_full;

  assign w_unused = ^{bus.IO_mem_addr[31:23],
                      bus.IO_mem_addr[21:4],
                      bus.IO_mem_addr[1:0],
                      bus.IO_mem_wdata};

  assign w_bit_end = (r_baud == r_div_q - 1'b1);

  // Pop on the edge that starts a frame: from IDLE,
  // or straight out of the last STOP cycle.
  assign w_pop = ~w_empty &
                 ((r_state == S_IDLE) |
                  ((r_state == S_STOP) & w_bit_end));

  assign tx_idle = w_empty & (r_state == S_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (bus.IO_mem_wdata[7:0]),
    .dout   (w_dout),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_comb begin
    bus.IO_mem_rdata = '0;
    if (w_sel) begin
      unique case (1'b1)
        (w_idx == REG_STATUS): begin
          bus.IO_mem_rdata[ST_BUSY]  = (r_state != S_IDLE);
          bus.IO_mem_rdata[ST_FULL]  = w_full;
          bus.IO_mem_rdata[ST_EMPTY] = w_empty;
          bus.IO_mem_rdata[ST_OVF]   = r_ovf;
          bus.IO_mem_rdata[ST_CNT_LSB +: 8] = 8'(w_count);
        end
        (w_idx == REG_DIV):
          bus.IO_mem_rdata = 32'(r_div);
        default:
          bus.IO_mem_rdata = '0;
      endcase
    end
  end

  // Full is the pre-edge value, so a same-cycle pop
  // never rescues a push into a full FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
      r_div <= DIV_BITS'(DEFAULT_DIV);
    end else begin
      if (w_wr_data & w_full)
        r_ovf <= 1'b1;
      else if (w_wr_stat & bus.IO_mem_wdata[ST_OVF])
        r_ovf <= 1'b0;
      if (w_wr_div)
        r_div <= (w_div_in < DIV_BITS'(MIN_DIV)) ?
                 DIV_BITS'(MIN_DIV) : w_div_in;
    end
  end

  // div_q is latched per frame so DIV writes only
  // affect the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_div_q  <= DIV_BITS'(DEFAULT_DIV);
      r_bit    <= '0;
      r_shift  <= '0;
      uart_txd <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state  <= S_START;
            r_shift  <= w_dout;
            r_div_q  <= r_div;
            r_baud   <= '0;
            uart_txd <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_state  <= S_DATA;
            uart_txd <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state  <= S_STOP;
              uart_txd <= 1'b1;
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_shift  <= {1'b0, r_shift[7:1]};
              uart_txd <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_state  <= S_START;
              r_shift  <= w_dout;
              r_div_q  <= r_div;
              uart_txd <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              uart_txd <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx_responder.sv
// Directed bench for io_uart_tx_responder:
// register vectors table plus frame/overflow/reset sequences.
module tb_io_uart_tx_responder;

  logic clk;
  logic resetn;
  logic uart_txd;
  logic tx_idle;
  int   checks;
  int   errors;

  io_uart_tx_responder_if bus ();

  io_uart_tx_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .uart_txd (uart_txd),
    .tx_idle  (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    bus.IO_mem_addr  = a;
    bus.IO_mem_wdata = d;
    bus.IO_mem_wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.IO_mem_wr = 1'b0;
  endtask

  task automatic rd(input string nm,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    bus.IO_mem_addr = a;
    #1;
    chk(nm, bus.IO_mem_rdata, exp);
  endtask

  // Call #1 after the frame's first edge; returns
  // #1 after the edge following the frame.
  task automatic check_frame(input logic [7:0] b,
                             input int div,
                             input string nm);
    int   bad;
    int   k;
    logic e;
    bad = 0;
    for (int i = 0; i < 10 * div; i++) begin
      k = i / div;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      if (uart_txd !== e) bad++;
      @(posedge clk);
      #1;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    checks = 0;
    errors = 0;

    vecs[0]  = '{"stat_rst",   0, 0, 0, 32'h400004, 32'h4};
    vecs[1]  = '{"div_rst",    0, 0, 0, 32'h400008, 32'd217};
    vecs[2]  = '{"data_rd",    0, 0, 0, 32'h400000, 32'h0};
    vecs[3]  = '{"rsv_rd",     0, 0, 0, 32'h40000C, 32'h0};
    vecs[4]  = '{"nosel_rd",   0, 0, 0, 32'h000004, 32'h0};
    vecs[5]  = '{"div_min1",   1, 32'h400008, 32'h1,
                 32'h400008, 32'h2};
    vecs[6]  = '{"div_min0",   1, 32'h400008, 32'h0,
                 32'h400008, 32'h2};
    vecs[7]  = '{"div_lowbit", 1, 32'h40000A, 32'h1234,
                 32'h400008, 32'h1234};
    vecs[8]  = '{"div_nosel",  1, 32'h000008, 32'h55,
                 32'h400008, 32'h1234};
    vecs[9]  = '{"rsv_wr",     1, 32'h40000C, 32'hFF,
                 32'h40000C, 32'h0};
    vecs[10] = '{"stat_wr",    1, 32'h400004, 32'hFFFFFFFF,
                 32'h400004, 32'h4};
    vecs[11] = '{"div_trunc",  1, 32'h00C00008, 32'hABCD0007,
                 32'h400008, 32'h7};
    vecs[12] = '{"div_hiaddr", 0, 0, 0, 32'h00C00008, 32'h7};

    resetn           = 1'b0;
    bus.IO_mem_addr  = '0;
    bus.IO_mem_wdata = '0;
    bus.IO_mem_wr    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("txd_rst",  32'(uart_txd), 32'd1);
    chk("idle_rst", 32'(tx_idle),  32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // Single frame, DIV=4
    wr(32'h400008, 32'd4);
    wr(32'h400000, 32'h55);
    @(posedge clk);
    #1;
    chk("busy_55", 32'(tx_idle), 32'd0);
    check_frame(8'h55, 4, "frame_55");
    chk("idle_55", 32'(tx_idle), 32'd1);

    // Back-to-back frames, no idle gap
    wr(32'h400000, 32'hA5);
    bus.IO_mem_wdata = 32'h3C;
    bus.IO_mem_wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.IO_mem_wr = 1'b0;
    rd("cnt_b2b", 32'h400004, 32'h101);
    check_frame(8'hA5, 4, "frame_A5");
    check_frame(8'h3C, 4, "frame_3C");
    chk("idle_b2b", 32'(tx_idle), 32'd1);

    // DIV change mid-frame
    wr(32'h400008, 32'd1);
    wr(32'h400000, 32'h0F);
    @(posedge clk);
    #1;
    fork
      begin
        check_frame(8'h0F, 2, "frame_div2");
        check_frame(8'hF0, 8, "frame_div8");
      end
      begin
        bus.IO_mem_addr  = 32'h400000;
        bus.IO_mem_wdata = 32'hF0;
        bus.IO_mem_wr    = 1'b1;
        @(posedge clk);
        #1;
        bus.IO_mem_addr  = 32'h400008;
        bus.IO_mem_wdata = 32'd8;
        @(posedge clk);
        #1;
        bus.IO_mem_wr = 1'b0;
      end
    join
    chk("idle_div", 32'(tx_idle), 32'd1);
    rd("div8_rd", 32'h400008, 32'd8);

    // Overflow while FSM is held busy
    wr(32'h400008, 32'hFFFF);
    wr(32'h400000, 32'h11);
    for (int i = 0; i < 16; i++)
      wr(32'h400000, 32'(i));
    rd("full_noovf", 32'h400004, 32'h1003);
    wr(32'h400000, 32'hEE);
    rd("ovf_set", 32'h400004, 32'h100B);
    wr(32'h400004, 32'h7);
    rd("ovf_keep", 32'h400004, 32'h100B);
    wr(32'h400004, 32'h8);
    rd("ovf_clr", 32'h400004, 32'h1003);

    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd("flush_stat", 32'h400004, 32'h4);
    rd("flush_div",  32'h400008, 32'd217);

    // Reset during DATA bit 3
    wr(32'h400008, 32'd4);
    wr(32'h400000, 32'hC3);
    bus.IO_mem_wdata = 32'h81;
    bus.IO_mem_wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.IO_mem_wr = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("txd_bit3", 32'(uart_txd), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("txd_async", 32'(uart_txd), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    rd("rst_stat", 32'h400004, 32'h4);
    rd("rst_div",  32'h400008, 32'd217);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (uart_txd !== 1'b1 || tx_idle !== 1'b1) bad++;
    end
    chk("no_frame", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
